// File: rtl/eprom_word_reader.sv
// eprom_word_reader
// Clocked word-read sequencer for a high/low pair of 27256-style 32Kx8 boot
// EPROMs. A request walks IDLE -> SETUP -> ACCESS -> DONE. In SETUP, CE_n is
// asserted. In ACCESS, OE_n is held low for ACCESS_CYCLES clocks before both
// byte lanes are captured. In DONE, a one-cycle ack is returned. Every output
// is driven straight from a flop.
//
// Build option: define EPROM_RD_PREFETCH_EN to add a one-word sequential
// prefetch buffer. After each read, the next word (rom_addr+1, wrapping) is
// fetched into pf_data/pf_addr. A matching request is then acked one clock
// after it is seen.
module eprom_word_reader #(
  parameter int ADDR_W        = 15,
  parameter int ACCESS_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              ack,
  output logic [15:0]       rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ce_n,
  output logic              rom_oe_n,
  input  logic [7:0]        rom_data_h,
  input  logic [7:0]        rom_data_l
);

  if ((ACCESS_CYCLES < 1) || (ACCESS_CYCLES > 15)) begin : g_bad_access_cycles
    $error("eprom_word_reader: ACCESS_CYCLES must be in the range 1..15");
  end

  // The counter is loaded with ACCESS_CYCLES-1. Capture happens on the clock
  // where the counter reads zero, so ACCESS lasts exactly ACCESS_CYCLES clocks.
  localparam logic [3:0]        CNT_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef EPROM_RD_PREFETCH_EN
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_ACCESS    = 3'd2,
    S_DONE      = 3'd3,
    S_PF_SETUP  = 3'd4,
    S_PF_ACCESS = 3'd5
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;

`ifdef EPROM_RD_PREFETCH_EN
  logic              pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic [15:0]       pf_data_q, pf_data_d;
`endif

  // Next-state, access counter, address latch and data capture decode;
  // the pin and handshake outputs are derived from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef EPROM_RD_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_addr_d  = pf_addr_q;
    pf_data_d  = pf_data_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d = req_addr;
`ifdef EPROM_RD_PREFETCH_EN
          if (pf_valid_q && (req_addr == pf_addr_q)) begin
            // Hit: return the buffered word at once, then refill from req_addr+1
            data_d  = pf_data_q;
            state_d = S_DONE;
          end else begin
            pf_valid_d = 1'b0;
            state_d    = S_SETUP;
          end
`else
          state_d = S_SETUP;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          data_d  = {rom_data_h, rom_data_l};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
`ifdef EPROM_RD_PREFETCH_EN
        // Address wraps naturally from all-ones to zero
        addr_d  = addr_q + ADDR_ONE;
        state_d = S_PF_SETUP;
`else
        state_d = S_IDLE;
`endif
      end

`ifdef EPROM_RD_PREFETCH_EN
      S_PF_SETUP: begin
        cnt_d   = CNT_LOAD;
        state_d = S_PF_ACCESS;
      end

      S_PF_ACCESS: begin
        if (cnt_q == 4'd0) begin
          pf_data_d  = {rom_data_h, rom_data_l};
          pf_addr_d  = addr_q;
          pf_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ack_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
`ifdef EPROM_RD_PREFETCH_EN
    ce_n_d = !((state_d == S_SETUP) || (state_d == S_ACCESS) ||
               (state_d == S_PF_SETUP) || (state_d == S_PF_ACCESS));
    oe_n_d = !((state_d == S_ACCESS) || (state_d == S_PF_ACCESS));
`else
    ce_n_d = !((state_d == S_SETUP) || (state_d == S_ACCESS));
    oe_n_d = !(state_d == S_ACCESS);
`endif
  end

  // State, counter, address, captured word and registered pin outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
    end
  end

`ifdef EPROM_RD_PREFETCH_EN
  // Prefetch buffer: one word plus its address and a valid flag
  always_ff @(posedge clk) begin
    if (reset) begin
      pf_valid_q <= 1'b0;
      pf_addr_q  <= '0;
      pf_data_q  <= 16'h0000;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_addr_q  <= pf_addr_d;
      pf_data_q  <= pf_data_d;
    end
  end
`endif

  assign ack      = ack_q;
  assign rd_data  = data_q;
  assign busy     = busy_q;
  assign rom_addr = addr_q;
  assign rom_ce_n = ce_n_q;
  assign rom_oe_n = oe_n_q;

endmodule

// File: tb/tb_eprom_word_reader.sv
// Scoreboard bench for eprom_word_reader. DUT A uses ACCESS_CYCLES=4 and DUT B
// uses ACCESS_CYCLES=2. Both drive behavioural 27256 models: high lane =
// addr[7:0]^A5, low lane = addr[14:8]. A model can present its data 3 clocks
// after OE_n falls. Prefetch-specific expectations follow
// EPROM_RD_PREFETCH_EN.
`timescale 1ns/1ps
module tb_eprom_word_reader;
  localparam int AW = 15;
`ifdef EPROM_RD_PREFETCH_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 6;
`endif

  typedef struct packed { logic [15:0] data; logic [7:0] lat; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic a_req = 1'b0, b_req = 1'b0;
  logic [AW-1:0] a_req_addr = '0, b_req_addr = '0;
  logic a_ack, b_ack, a_busy, b_busy, a_ce_n, b_ce_n, a_oe_n, b_oe_n;
  logic [15:0] a_rd_data, b_rd_data;
  logic [AW-1:0] a_rom_addr, b_rom_addr;
  logic [7:0] a_dh, a_dl, b_dh, b_dl;

  exp_t a_q[$];
  exp_t b_q[$];
  int   a_s[$];
  int   b_s[$];
  int   a_idle_run = 0;
  int   a_gap = 0;

  eprom_word_reader #(.ADDR_W(AW), .ACCESS_CYCLES(4)) u_dut_a (
    .clk(clk), .reset(reset), .req(a_req), .req_addr(a_req_addr),
    .ack(a_ack), .rd_data(a_rd_data), .busy(a_busy), .rom_addr(a_rom_addr),
    .rom_ce_n(a_ce_n), .rom_oe_n(a_oe_n), .rom_data_h(a_dh), .rom_data_l(a_dl)
  );

  eprom_word_reader #(.ADDR_W(AW), .ACCESS_CYCLES(2)) u_dut_b (
    .clk(clk), .reset(reset), .req(b_req), .req_addr(b_req_addr),
    .ack(b_ack), .rd_data(b_rd_data), .busy(b_busy), .rom_addr(b_rom_addr),
    .rom_ce_n(b_ce_n), .rom_oe_n(b_oe_n), .rom_data_h(b_dh), .rom_data_l(b_dl)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lane_h(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] lane_l(input logic [AW-1:0] a);
    return {1'b0, a[14:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // EPROM A: immediate when a_dly==0, otherwise data appears a_dly clocks after OE_n low
  int a_dly = 0;
  int a_cnt = 0;
  logic [7:0] a_mh = 8'hDE, a_ml = 8'hAD;
  always @(posedge clk) begin
    if (a_oe_n !== 1'b0) a_cnt <= 0;
    else begin
      a_cnt <= a_cnt + 1;
      if (a_cnt + 1 == a_dly) begin
        a_mh <= lane_h(a_rom_addr);
        a_ml <= lane_l(a_rom_addr);
      end
    end
  end
  assign a_dh = (a_dly == 0) ? lane_h(a_rom_addr) : a_mh;
  assign a_dl = (a_dly == 0) ? lane_l(a_rom_addr) : a_ml;

  // EPROM B: always 3 clocks slow; starts out holding stale word DEAD
  int b_cnt = 0;
  logic [7:0] b_mh = 8'hDE, b_ml = 8'hAD;
  always @(posedge clk) begin
    if (b_oe_n !== 1'b0) b_cnt <= 0;
    else begin
      b_cnt <= b_cnt + 1;
      if (b_cnt + 1 == 3) begin
        b_mh <= lane_h(b_rom_addr);
        b_ml <= lane_l(b_rom_addr);
      end
    end
  end
  assign b_dh = b_mh;
  assign b_dl = b_ml;

  // Monitor A: records IDLE request samples, checks each ack against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      a_s.delete();
      a_idle_run <= 0;
    end else begin
      if (a_ack === 1'b1) begin
        if (a_q.size() == 0 || a_s.size() == 0) check("A unexpected ack", 32'd1, 32'd0);
        else begin
          check("A rd_data", 32'(a_rd_data), 32'(a_q[0].data));
          check("A latency", 32'(cyc - a_s[0]), 32'(a_q[0].lat));
          void'(a_q.pop_front());
          void'(a_s.pop_front());
        end
      end
      if (a_req && a_busy === 1'b0) a_s.push_back(cyc);
      check("A ce_n high while oe_n low", 32'(a_ce_n && !a_oe_n), 32'd0);
      if (a_busy === 1'b1) begin
        if (a_idle_run != 0) a_gap <= a_idle_run;
        a_idle_run <= 0;
      end else a_idle_run <= a_idle_run + 1;
    end
  end

  // Monitor B: same scoreboard checking for the short-access instance
  always @(negedge clk) begin
    if (reset) b_s.delete();
    else begin
      if (b_ack === 1'b1) begin
        if (b_q.size() == 0 || b_s.size() == 0) check("B unexpected ack", 32'd1, 32'd0);
        else begin
          check("B rd_data", 32'(b_rd_data), 32'(b_q[0].data));
          check("B latency", 32'(cyc - b_s[0]), 32'(b_q[0].lat));
          void'(b_q.pop_front());
          void'(b_s.pop_front());
        end
      end
      if (b_req && b_busy === 1'b0) b_s.push_back(cyc);
      check("B ce_n high while oe_n low", 32'(b_ce_n && !b_oe_n), 32'd0);
    end
  end

  task automatic read_a(input logic [AW-1:0] addr, input logic [15:0] data, input int lat);
    int n;
    a_q.push_back({data, 8'(lat)});
    a_req = 1'b1;
    a_req_addr = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (a_ack !== 1'b1 && n < 64);
    if (a_ack !== 1'b1) check("A ack timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic read_b(input logic [AW-1:0] addr, input logic [15:0] data, input int lat);
    int n;
    b_q.push_back({data, 8'(lat)});
    b_req = 1'b1;
    b_req_addr = addr;
    n = 0;
    do begin @(negedge clk); n++; end while (b_ack !== 1'b1 && n < 64);
    if (b_ack !== 1'b1) check("B ack timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus
  initial begin
    logic [13:0] hist;
    int n;

    // Reset values
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset rom_ce_n", 32'(a_ce_n), 32'd1);
    check("reset rom_oe_n", 32'(a_oe_n), 32'd1);
    check("reset ack", 32'(a_ack), 32'd0);
    check("reset busy", 32'(a_busy), 32'd0);
    check("reset rd_data", 32'(a_rd_data), 32'd0);
    check("reset rom_addr", 32'(a_rom_addr), 32'd0);
    check("reset B pins", 32'({b_ce_n, b_oe_n, b_ack, b_busy}), 32'b1100);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle: no pin toggling while req is low
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle pins", 32'({a_ce_n, a_oe_n, a_busy}), 32'b110);
    end
    @(posedge clk); #1;

    // First read with an immediate model: CE_n low 1 clk, then OE_n low 4 clks, ack at T+6
    a_dly = 0;
    a_q.push_back({16'hA501, 8'd6});
    a_req = 1'b1;
    a_req_addr = 15'h0100;
    hist = '0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      hist = {hist[11:0], a_ce_n, a_oe_n};
      if (k == 1) a_req_addr = 15'h7777;
      if (k == 3) check("A rom_addr stable while busy", 32'(a_rom_addr), 32'h0100);
    end
    check("A pin sequence", 32'(hist), 32'(14'b11_01_00_00_00_00_11));
    @(posedge clk); #1;
    a_req = 1'b0;

    // Slow model: data valid 3 clks after OE_n low; 4 access clocks still capture it
    a_dly = 3;
    read_a(15'h0055, 16'hF000, 6);
    read_a(15'h2A3C, 16'h992A, 6);

    // Same slow model with only 2 access clocks: the capture sees the stale word
    read_b(15'h0100, 16'hDEAD, 4);
    read_b(15'h0003, 16'hDEAD, 4);

    // Reset during ACCESS aborts the read with no ack
    repeat (12) @(posedge clk);
    #1;
    a_req = 1'b1;
    a_req_addr = 15'h0055;
    n = 0;
    while (a_oe_n !== 1'b0 && n < 32) begin @(posedge clk); #1; n++; end
    check("A reached ACCESS before abort", 32'(a_oe_n), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    a_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort pins", 32'({a_ce_n, a_oe_n, a_ack, a_busy}), 32'b1100);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // A following read completes normally, and rd_data then holds
    read_a(15'h0002, 16'hA700, 6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("A rd_data holds", 32'(a_rd_data), 32'h0000_A700);
    @(posedge clk); #1;

`ifdef EPROM_RD_PREFETCH_EN
    // 7FFF misses; the following prefetch wraps to 0000
    read_a(15'h7FFF, 16'h5A7F, 6);
    n = 0;
    while (a_busy !== 1'b0 && n < 32) begin @(posedge clk); #1; n++; end
    check("A prefetch finished", 32'(a_busy), 32'd0);
    read_a(15'h0000, 16'hA500, HIT_LAT);
    read_a(15'h1234, 16'h9112, 6);
`else
    // Back-to-back reads: each is a full access; busy drops for exactly one clock
    read_a(15'h1234, 16'h9112, 6);
    read_a(15'h0003, 16'hA600, 6);
    check("A busy gap between reads", 32'(a_gap), 32'd1);
    read_a(15'h7FFF, 16'h5A7F, 6);
    read_a(15'h0000, 16'hA500, HIT_LAT);
`endif

    repeat (16) @(posedge clk);
    @(negedge clk);
    check("A scoreboard drained", 32'(a_q.size()), 32'd0);
    check("B scoreboard drained", 32'(b_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
